// File: rtl/hamming_disp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hamming_disp_scheduler
// Description : Drives the read side of the left/right census line buffers
//               for one matching window. For each disparity it sums the
//               Hamming cost (popcount of left XOR right) over the window,
//               saturating the sum, and keeps the lowest-cost disparity.
//               Ties go to the lower disparity.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_disp_scheduler #(
    parameter int WIN_WORDS = 4,
    parameter int MAX_DISP  = 16,
    parameter int AW        = 8,
    parameter int DW        = 5,
    parameter int CW        = 16
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          iStart,
    input  logic [AW-1:0] iBaseL,
    input  logic [AW-1:0] iBaseR,
    output logic          oRdEn,
    output logic [AW-1:0] oAddrL,
    output logic [AW-1:0] oAddrR,
    input  logic [31:0]   iDataL,
    input  logic [31:0]   iDataR,
    output logic          oBusy,
    output logic          oDone,
    output logic [DW-1:0] oDisp,
    output logic [CW-1:0] oCost
);

    // Word counter width; a one-word window still needs one bit.
    localparam int c_WW = (WIN_WORDS > 1) ? $clog2(WIN_WORDS) : 1;
    // Adder width: wide enough for the accumulator and a 0..32 popcount plus carry.
    localparam int c_SW = ((CW > 6) ? CW : 6) + 1;

    localparam logic [c_WW-1:0] c_LAST_W = c_WW'(WIN_WORDS - 1);
    localparam logic [DW-1:0]   c_LAST_D = DW'(MAX_DISP - 1);
    localparam logic [c_SW-1:0] c_SAT    = {{(c_SW-CW){1'b0}}, {CW{1'b1}}};

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [AW-1:0]   r_baseL;
    logic [AW-1:0]   r_addrL;
    logic [AW-1:0]   r_addrR;
    logic [c_WW-1:0] r_w;
    logic [DW-1:0]   r_d;

    logic            r_vld;
    logic            r_vLast;
    logic [DW-1:0]   r_vDisp;

    logic [CW-1:0]   r_acc;
    logic [CW-1:0]   r_bestCost;
    logic [DW-1:0]   r_bestDisp;

    logic            r_done;
    logic [DW-1:0]   r_outDisp;
    logic [CW-1:0]   r_outCost;

    logic [31:0]     w_xor;
    logic [5:0]      w_pop;
    logic [c_SW-1:0] w_sumWide;
    logic [CW-1:0]   w_sum;
    logic            w_take;
    logic [CW-1:0]   w_nextBestCost;
    logic [DW-1:0]   w_nextBestDisp;
    logic            w_accept;

    assign w_accept = (r_state == c_IDLE) && iStart;

    // Popcount of the returned word pair and saturating add into the running cost.
    always_comb begin
        w_xor = iDataL ^ iDataR;
        w_pop = '0;
        for (int i = 0; i < 32; i++) begin
            w_pop = w_pop + {5'd0, w_xor[i]};
        end
        w_sumWide = c_SW'(r_acc) + c_SW'(w_pop);
        w_sum     = (w_sumWide > c_SAT) ? c_SAT[CW-1:0] : w_sumWide[CW-1:0];
    end

    // Best-so-far update on the last word of a disparity; disparity 0 always seeds it.
    always_comb begin
        w_take         = r_vld && r_vLast && ((r_vDisp == '0) || (w_sum < r_bestCost));
        w_nextBestCost = w_take ? w_sum   : r_bestCost;
        w_nextBestDisp = w_take ? r_vDisp : r_bestDisp;
    end

    // Control FSM and read-address generation; the right address is linear across
    // the whole search, the left address re-walks the same window per disparity.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state <= c_IDLE;
            r_baseL <= '0;
            r_addrL <= '0;
            r_addrR <= '0;
            r_w     <= '0;
            r_d     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (iStart) begin
                        r_baseL <= iBaseL;
                        r_addrL <= iBaseL;
                        r_addrR <= iBaseR;
                        r_w     <= '0;
                        r_d     <= '0;
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_addrR <= r_addrR + AW'(1);
                    if (r_w == c_LAST_W) begin
                        r_w     <= '0;
                        r_addrL <= r_baseL;
                        r_d     <= r_d + DW'(1);
                        if (r_d == c_LAST_D) begin
                            r_state <= c_DRAIN;
                        end
                    end else begin
                        r_w     <= r_w + c_WW'(1);
                        r_addrL <= r_addrL + AW'(1);
                    end
                end
                c_DRAIN: r_state <= c_DONE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // One-stage valid pipe matching the buffer read latency, tagged with window position.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_vld   <= 1'b0;
            r_vLast <= 1'b0;
            r_vDisp <= '0;
        end else begin
            r_vld   <= (r_state == c_ISSUE);
            r_vLast <= (r_w == c_LAST_W);
            r_vDisp <= r_d;
        end
    end

    // Cost accumulation and best-disparity tracking, cleared on each accepted start.
    always_ff @(posedge iClk) begin
        if (iReset || w_accept) begin
            r_acc      <= '0;
            r_bestCost <= '0;
            r_bestDisp <= '0;
        end else if (r_vld) begin
            r_acc      <= r_vLast ? '0 : w_sum;
            r_bestCost <= w_nextBestCost;
            r_bestDisp <= w_nextBestDisp;
        end
    end

    // Result registers load while leaving DRAIN so they are valid alongside oDone.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_done    <= 1'b0;
            r_outDisp <= '0;
            r_outCost <= '0;
        end else begin
            r_done <= (r_state == c_DRAIN);
            if (r_state == c_DRAIN) begin
                r_outDisp <= w_nextBestDisp;
                r_outCost <= w_nextBestCost;
            end
        end
    end

    assign oRdEn  = (r_state == c_ISSUE);
    assign oBusy  = (r_state == c_ISSUE) || (r_state == c_DRAIN);
    assign oAddrL = r_addrL;
    assign oAddrR = r_addrR;
    assign oDone  = r_done;
    assign oDisp  = r_outDisp;
    assign oCost  = r_outCost;

endmodule
`default_nettype wire
